// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: sends each vector of a batch through a chain of stages
// (MVProd, Bias, ReLU). It grants one stage at a time and inserts a one-cycle
// ready gap between stages. Each stage has a bounded time to answer, and a
// stage that misses it parks the block in a sticky error state.
module pipeline_sequencer #(
  parameter int NumStages     = 3,
  parameter int NumVectors    = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_vec_avail,
  input  logic                 out_space,
  input  logic [NumStages-1:0] stage_vec_valid,
  output logic [NumStages-1:0] stage_data_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic [2:0]           err_stage,
  output logic [7:0]           vec_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_IN  = 3'd1,
    ST_RUN      = 3'd2,
    ST_GAP      = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } state_e;

  localparam logic [2:0]  KLast   = 3'(NumStages - 1);
  localparam logic [15:0] TmoLast = 16'(TimeoutCycles - 1);
  localparam logic [7:0]  VecLast = 8'(NumVectors);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [2:0]           r_k;
  logic [2:0]           w_k_nxt;
  logic [15:0]          r_tmo;
  logic [7:0]           r_vec_count;
  logic [7:0]           w_vec_inc;
  logic [NumStages-1:0] w_k_onehot;
  logic                 w_valid_sel;
  logic [NumStages-1:0] w_ready_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_err_nxt;
  logic [2:0]           w_err_stage_nxt;

  // Only the active stage's valid bit is observed.
  assign w_k_onehot  = NumStages'(1'b1) << r_k;
  assign w_valid_sel = |(stage_vec_valid & w_k_onehot);
  // The completed-vector count saturates and never wraps.
  assign w_vec_inc   = (r_vec_count == 8'hFF) ? 8'hFF : r_vec_count + 8'd1;
  assign vec_count   = r_vec_count;

  // State register together with the active stage index.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
      r_k     <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Next-state and next-stage-index selection; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_k_nxt     = 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_WAIT_IN;
            w_k_nxt     = 3'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WAIT_IN: begin
          if (in_vec_avail) begin
            w_state_nxt = ST_RUN;
            w_k_nxt     = 3'd0;
          end else begin
            w_state_nxt = ST_WAIT_IN;
          end
        end
        ST_RUN: begin
          // A valid bit in the final allowed cycle still counts as success.
          if (w_valid_sel) begin
            w_state_nxt = ST_GAP;
          end else if (r_tmo == TmoLast) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_GAP: begin
          if (r_k != KLast) begin
            w_state_nxt = ST_RUN;
            w_k_nxt     = r_k + 3'd1;
          end else begin
            w_state_nxt = ST_WAIT_OUT;
          end
        end
        ST_WAIT_OUT: begin
          if (!out_space) begin
            w_state_nxt = ST_WAIT_OUT;
          end else if (w_vec_inc == VecLast) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_WAIT_IN;
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        ST_ERR:  w_state_nxt = ST_ERR;
        default: begin
          w_state_nxt = ST_IDLE;
          w_k_nxt     = 3'd0;
        end
      endcase
    end
  end

  // Per-stage timeout counter and the batch vector counter.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_tmo       <= 16'd0;
      r_vec_count <= 8'd0;
    end else begin
      if (r_state == ST_RUN && !abort) begin
        r_tmo <= r_tmo + 16'd1;
      end else begin
        r_tmo <= 16'd0;
      end
      if (abort) begin
        r_vec_count <= r_vec_count;
      end else if (r_state == ST_IDLE && start) begin
        r_vec_count <= 8'd0;
      end else if (r_state == ST_WAIT_OUT && out_space) begin
        r_vec_count <= w_vec_inc;
      end else begin
        r_vec_count <= r_vec_count;
      end
    end
  end

  // Output decode from the upcoming state so registered outputs align with it.
  always_comb begin
    w_ready_nxt     = {NumStages{1'b0}};
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_stage_nxt = err_stage;
    case (w_state_nxt)
      ST_WAIT_IN, ST_GAP, ST_WAIT_OUT: w_busy_nxt = 1'b1;
      ST_RUN: begin
        w_busy_nxt  = 1'b1;
        w_ready_nxt = NumStages'(1'b1) << w_k_nxt;
      end
      ST_DONE: w_done_nxt = 1'b1;
      ST_ERR:  w_err_nxt  = 1'b1;
      default: w_busy_nxt = 1'b0;
    endcase
    if (r_state == ST_RUN && w_state_nxt == ST_ERR) begin
      w_err_stage_nxt = r_k;
    end else begin
      w_err_stage_nxt = err_stage;
    end
  end

  // Output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stage_data_ready <= {NumStages{1'b0}};
      busy             <= 1'b0;
      done             <= 1'b0;
      err_timeout      <= 1'b0;
      err_stage        <= 3'd0;
    end else begin
      stage_data_ready <= w_ready_nxt;
      busy             <= w_busy_nxt;
      done             <= w_done_nxt;
      err_timeout      <= w_err_nxt;
      err_stage        <= w_err_stage_nxt;
    end
  end

endmodule
